// File: rtl/vga_rect_fill.sv
// Rectangle fill engine feeding the VGA framebuffer write port.
// Takes one clipped rectangle command and emits one held write per pixel, row-major.
module vga_rect_fill #(
    parameter int unsigned FB_WIDTH   = 40,
    parameter int unsigned FB_HEIGHT  = 30,
    parameter int unsigned ADDR_WIDTH = 17,
    parameter int unsigned WRITE_HOLD = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [9:0]            cmd_x,
    input  logic [9:0]            cmd_y,
    input  logic [9:0]            cmd_w,
    input  logic [9:0]            cmd_h,
    input  logic [2:0]            cmd_color,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [2:0]            wr_data
);

    localparam int unsigned HoldW = (WRITE_HOLD > 1) ? $clog2(WRITE_HOLD) : 1;

    localparam logic [10:0]           FbW11   = 11'(FB_WIDTH);
    localparam logic [10:0]           FbH11   = 11'(FB_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] FbWAddr = ADDR_WIDTH'(FB_WIDTH);
    localparam logic [HoldW-1:0]      HoldMax = HoldW'(WRITE_HOLD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StClip,
        StFill,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [9:0]            x_q, x_d;
    logic [9:0]            y_q, y_d;
    logic [9:0]            w_q, w_d;
    logic [9:0]            h_q, h_d;
    logic [2:0]            color_q, color_d;
    logic [10:0]           x_end_q, x_end_d;
    logic [10:0]           y_end_q, y_end_d;
    logic [9:0]            col_q, col_d;
    logic [9:0]            row_q, row_d;
    logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
    logic [HoldW-1:0]      hold_q, hold_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]            wr_data_q, wr_data_d;

    logic [10:0]           x_sum, y_sum;
    logic                  empty;
    logic [ADDR_WIDTH-1:0] y_base;

    // Sums are one bit wider than the operands, so they never wrap.
    assign x_sum  = {1'b0, x_q} + {1'b0, w_q};
    assign y_sum  = {1'b0, y_q} + {1'b0, h_q};
    assign empty  = (w_q == 10'd0) || (h_q == 10'd0) ||
                    ({1'b0, x_q} >= FbW11) || ({1'b0, y_q} >= FbH11);
    assign y_base = ADDR_WIDTH'(y_q) * FbWAddr;

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        hold_d     = hold_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    x_d     = cmd_x;
                    y_d     = cmd_y;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = StClip;
                end
            end
            StClip: begin
                x_end_d = (x_sum > FbW11) ? FbW11 : x_sum;
                y_end_d = (y_sum > FbH11) ? FbH11 : y_sum;
                if (empty) begin
                    state_d = StDone;
                end else begin
                    col_d      = x_q;
                    row_d      = y_q;
                    row_base_d = y_base;
                    hold_d     = '0;
                    wr_addr_d  = y_base + ADDR_WIDTH'(x_q);
                    wr_data_d  = color_q;
                    state_d    = StFill;
                end
            end
            StFill: begin
                if (hold_q == HoldMax) begin
                    hold_d = '0;
                    if (({1'b0, col_q} + 11'd1) < x_end_q) begin
                        col_d     = col_q + 10'd1;
                        wr_addr_d = row_base_q + ADDR_WIDTH'(col_q) + ADDR_WIDTH'(1);
                    end else if (({1'b0, row_q} + 11'd1) < y_end_q) begin
                        row_d      = row_q + 10'd1;
                        col_d      = x_q;
                        row_base_d = row_base_q + FbWAddr;
                        wr_addr_d  = row_base_q + FbWAddr + ADDR_WIDTH'(x_q);
                    end else begin
                        state_d = StDone;
                    end
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            hold_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            hold_q     <= hold_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Status and write strobe are pure decodes of the state register, so they
    // drop together the instant reset is asserted.
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign wr_en     = (state_q == StFill);
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule
